inst_loader: RTL and testbench

Boot-time program loader that writes the instruction memory, the write side of the instruction store the fetch stage reads. It accepts a framed little-endian byte stream over a valid/ready handshake, assembles 32-bit words, and drives the memory's write port (`wren`/`wraddr`/`wrdata`) with sequential word addresses from 0. It holds the core in reset via `core_hold` until a complete, verified image is in memory.

---
 rtl/inst_loader.sv | 142 ++++++++++++++
 tb/tb_inst_loader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Boot loader: framed byte stream -> instruction memory write port.
// Optional LOADER_CKSUM_EN adds a trailing mod-256 payload checksum byte.
module inst_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wren,
  output logic [ADDR_W-1:0] wraddr,
  output logic [31:0]       wrdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  localparam int         CW  = ADDR_W + 1;
  localparam logic [16:0] CAP = 17'(1) << ADDR_W;

  state_t        state;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [1:0]    bidx;
  logic [23:0]   asm_q;
  logic          acc;
  logic          is_hdr;
  logic [16:0]   n_len;
  logic [CW-1:0] cnt_nxt;
  logic          last_word;
`ifdef LOADER_CKSUM_EN
  logic [7:0]    sum;
`endif

  assign in_ready  = ~rst;
  assign acc       = in_valid & in_ready;
  assign is_hdr    = (in_data == HDR);
  assign n_len     = {1'b0, in_data, len_lo};
  assign cnt_nxt   = words_loaded + CW'(1);
  assign last_word = (17'(cnt_nxt) == {1'b0, len});

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      len_lo       <= '0;
      len          <= '0;
      bidx         <= '0;
      asm_q        <= '0;
      wren         <= 1'b0;
      wraddr       <= '0;
      wrdata       <= '0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
`ifdef LOADER_CKSUM_EN
      sum          <= '0;
`endif
    end else begin
      wren <= 1'b0;
      // release lags DONE entry by one edge so the last write commits first
      done      <= (state == S_DONE) && !(acc && is_hdr);
      core_hold <= !((state == S_DONE) && !(acc && is_hdr));
      if (acc) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_hdr) begin
              state <= S_LEN0;
              err   <= 1'b0;
            end
          end
          S_LEN0: begin
            len_lo <= in_data;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            len <= {in_data, len_lo};
            if (n_len == 17'd0 || n_len > CAP) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              words_loaded <= '0;
              bidx         <= '0;
`ifdef LOADER_CKSUM_EN
              sum          <= '0;
`endif
              state        <= S_DATA;
            end
          end
          S_DATA: begin
`ifdef LOADER_CKSUM_EN
            sum  <= sum + in_data;
`endif
            bidx <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              wren         <= 1'b1;
              wraddr       <= words_loaded[ADDR_W-1:0];
              wrdata       <= {in_data, asm_q};
              words_loaded <= cnt_nxt;
              if (last_word) begin
`ifdef LOADER_CKSUM_EN
                state <= S_CKSUM;
`else
                state <= S_DONE;
`endif
              end
            end else begin
              asm_q[8*bidx +: 8] <= in_data;
            end
          end
`ifdef LOADER_CKSUM_EN
          S_CKSUM: begin
            if (in_data == sum) begin
              state <= S_DONE;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: framing, writes, release, errors, reset.
// Works with or without LOADER_CKSUM_EN.
module tb_inst_loader;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready;
  logic              wren;
  logic [ADDR_W-1:0] wraddr;
  logic [31:0]       wrdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   words_loaded;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] ck;
  logic [ADDR_W-1:0] qa[$];
  logic [31:0]       qd[$];

  inst_loader #(.ADDR_W(ADDR_W), .HDR(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .wren(wren),
    .wraddr(wraddr),
    .wrdata(wrdata),
    .core_hold(core_hold),
    .done(done),
    .err(err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wren === 1'b1) begin
      qa.push_back(wraddr);
      qd.push_back(wrdata);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_hdr_len(input logic [15:0] n);
    ck = 8'h00;
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      ck = ck + w[8*i +: 8];
      send_byte(w[8*i +: 8]);
    end
  endtask

  task automatic send_ck(input bit good);
`ifdef LOADER_CKSUM_EN
    send_byte(good ? ck : ck + 8'd1);
`else
    if (!good) ck = ck;
`endif
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_in_ready got=%b exp=0", in_ready);
    end
    n_vec++;
    if ({wren, wraddr, wrdata, core_hold, done, err, words_loaded} !==
        {1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL rst_outputs got wren=%b a=%0d d=%h hold=%b done=%b err=%b wl=%0d",
               wren, wraddr, wrdata, core_hold, done, err, words_loaded);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_rst got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_basic;
    qa.delete();
    qd.delete();
    send_hdr_len(16'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_ck(1'b1);
    n_vec++;
    if (done !== 1'b0 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL basic_early_release got done=%b hold=%b exp 0/1", done, core_hold);
    end
    tick;
    n_vec++;
    if (done !== 1'b1 || core_hold !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL basic_release got done=%b hold=%b err=%b exp 1/0/0", done, core_hold, err);
    end
    n_vec++;
    if (words_loaded !== 11'd2) begin
      n_err++;
      $display("FAIL basic_words got=%0d exp=2", words_loaded);
    end
    n_vec++;
    if (qa.size() != 2) begin
      n_err++;
      $display("FAIL basic_nwrites got=%0d exp=2", qa.size());
    end else if (qa[0] !== 10'd0 || qd[0] !== 32'h00000013 ||
                 qa[1] !== 10'd1 || qd[1] !== 32'h00100093) begin
      n_err++;
      $display("FAIL basic_writes got %0d:%h %0d:%h exp 0:00000013 1:00100093",
               qa[0], qd[0], qa[1], qd[1]);
    end
    n_vec++;
    if (wraddr !== 10'd1 || wrdata !== 32'h00100093 || wren !== 1'b0) begin
      n_err++;
      $display("FAIL basic_hold got a=%0d d=%h wren=%b exp 1 00100093 0", wraddr, wrdata, wren);
    end
  endtask

  task automatic test_bad_cksum;
`ifdef LOADER_CKSUM_EN
    qa.delete();
    qd.delete();
    send_hdr_len(16'd2);
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_ck(1'b0);
    tick;
    n_vec++;
    if (qa.size() != 2) begin
      n_err++;
      $display("FAIL badck_nwrites got=%0d exp=2", qa.size());
    end
    n_vec++;
    if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL badck_flags got err=%b done=%b hold=%b exp 1/0/1", err, done, core_hold);
    end
`endif
  endtask

  task automatic test_junk;
    qa.delete();
    qd.delete();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_hdr_len(16'd1);
    send_word(32'h12345678);
    send_ck(1'b1);
    tick;
    n_vec++;
    if (qa.size() != 1) begin
      n_err++;
      $display("FAIL junk_nwrites got=%0d exp=1", qa.size());
    end else if (qa[0] !== 10'd0 || qd[0] !== 32'h12345678) begin
      n_err++;
      $display("FAIL junk_write got %0d:%h exp 0:12345678", qa[0], qd[0]);
    end
    n_vec++;
    if (done !== 1'b1 || err !== 1'b0 || core_hold !== 1'b0 || words_loaded !== 11'd1) begin
      n_err++;
      $display("FAIL junk_flags got done=%b err=%b hold=%b wl=%0d exp 1/0/0/1",
               done, err, core_hold, words_loaded);
    end
  endtask

  task automatic test_bad_len;
    qa.delete();
    qd.delete();
    send_hdr_len(16'd0);
    n_vec++;
    if (err !== 1'b1 || done !== 1'b0 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL len0_flags got err=%b done=%b hold=%b exp 1/0/1", err, done, core_hold);
    end
    send_byte(8'hA5);
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL err_clear_on_hdr got=%b exp=0", err);
    end
    send_byte(8'h01);
    send_byte(8'h04);
    n_vec++;
    if (err !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL len1025_flags got err=%b done=%b exp 1/0", err, done);
    end
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    tick;
    n_vec++;
    if (qa.size() != 0 || err !== 1'b1) begin
      n_err++;
      $display("FAIL badlen_nowrite got writes=%0d err=%b exp 0/1", qa.size(), err);
    end
  endtask

  task automatic test_full_capacity;
    int bad;
    qa.delete();
    qd.delete();
    send_hdr_len(16'd1024);
    for (int i = 0; i < 1024; i++) send_word(32'hA5A50000 ^ 32'(i));
    send_ck(1'b1);
    tick;
    bad = 0;
    if (qa.size() != 1024) bad = 1;
    else
      for (int i = 0; i < 1024; i++)
        if (qa[i] !== 10'(i) || qd[i] !== (32'hA5A50000 ^ 32'(i))) bad++;
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL full_writes got nwrites=%0d bad=%0d exp 1024/0", qa.size(), bad);
    end
    n_vec++;
    if (words_loaded !== 11'd1024 || done !== 1'b1 || err !== 1'b0 || wraddr !== 10'd1023) begin
      n_err++;
      $display("FAIL full_flags got wl=%0d done=%b err=%b a=%0d exp 1024/1/0/1023",
               words_loaded, done, err, wraddr);
    end
  endtask

  task automatic test_rst_mid;
    send_hdr_len(16'd2);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h93);
    send_byte(8'h00);
    @(negedge clk);
    rst = 1'b1;
    tick;
    n_vec++;
    if ({in_ready, wren, wraddr, wrdata, core_hold, done, err, words_loaded} !==
        {1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 11'd0}) begin
      n_err++;
      $display("FAIL midrst_outputs got rdy=%b wren=%b a=%0d d=%h hold=%b done=%b err=%b wl=%0d",
               in_ready, wren, wraddr, wrdata, core_hold, done, err, words_loaded);
    end
    rst = 1'b0;
    qa.delete();
    qd.delete();
    send_hdr_len(16'd2);
    send_word(32'hDEADBEEF);
    send_word(32'h0BADF00D);
    send_ck(1'b1);
    tick;
    n_vec++;
    if (qa.size() != 2) begin
      n_err++;
      $display("FAIL midrst_nwrites got=%0d exp=2", qa.size());
    end else if (qa[0] !== 10'd0 || qd[0] !== 32'hDEADBEEF ||
                 qa[1] !== 10'd1 || qd[1] !== 32'h0BADF00D) begin
      n_err++;
      $display("FAIL midrst_writes got %0d:%h %0d:%h exp 0:deadbeef 1:0badf00d",
               qa[0], qd[0], qa[1], qd[1]);
    end
    n_vec++;
    if (done !== 1'b1 || core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_release got done=%b hold=%b exp 1/0", done, core_hold);
    end
  endtask

  task automatic test_restart;
    qa.delete();
    qd.delete();
    ck = 8'h00;
    send_byte(8'hA5);
    n_vec++;
    if (core_hold !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_hold got hold=%b done=%b exp 1/0", core_hold, done);
    end
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(32'hCAFE0001);
    send_ck(1'b1);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL restart_early got done=%b exp=0", done);
    end
    tick;
    n_vec++;
    if (qa.size() != 1) begin
      n_err++;
      $display("FAIL restart_nwrites got=%0d exp=1", qa.size());
    end else if (qa[0] !== 10'd0 || qd[0] !== 32'hCAFE0001) begin
      n_err++;
      $display("FAIL restart_write got %0d:%h exp 0:cafe0001", qa[0], qd[0]);
    end
    n_vec++;
    if (done !== 1'b1 || core_hold !== 1'b0 || words_loaded !== 11'd1) begin
      n_err++;
      $display("FAIL restart_release got done=%b hold=%b wl=%0d exp 1/0/1",
               done, core_hold, words_loaded);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_cksum;
    test_junk;
    test_bad_len;
    test_full_capacity;
    test_rst_mid;
    test_restart;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
